// File: rtl/line_mem_arbiter.sv
// ---------------------------------------------------------------------------
// line_mem_arbiter
//
// Shares one line-wide main-memory port between the icache miss path (reads
// only) and the dcache miss/writeback path (reads and writes). Each access
// holds the memory port for MEM_LATENCY cycles. The full line then goes back
// to the winning requester with a one-cycle ready pulse.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : a tie goes to the requester that did not win last time.
//   undefined : fixed priority, so the dcache always wins a tie.
//
// Parameters:
//   MEM_LATENCY  memory access cycles (>= 1)
//   ADDR_WIDTH   byte address width
//   Line width comes from the global `LINE_WIDTH macro.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr        icache line-read request (held until ic_ready)
//   ic_ready/ic_line      icache completion pulse and returned line
//   dc_req/dc_we/dc_addr  dcache request (held until dc_ready), 1 = write
//   dc_wline              dcache writeback data
//   dc_ready/dc_rline     dcache completion pulse and read line
//   mem_en/mem_we         memory access active / memory write
//   mem_addr/mem_wline    memory address / write data
//   mem_rline             memory read data, valid in the last BUSY cycle
// ---------------------------------------------------------------------------
`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif

module line_mem_arbiter #(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req,
    input  logic [ADDR_WIDTH-1:0]  ic_addr,
    output logic                   ic_ready,
    output logic [`LINE_WIDTH-1:0] ic_line,
    input  logic                   dc_req,
    input  logic                   dc_we,
    input  logic [ADDR_WIDTH-1:0]  dc_addr,
    input  logic [`LINE_WIDTH-1:0] dc_wline,
    output logic                   dc_ready,
    output logic [`LINE_WIDTH-1:0] dc_rline,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [`LINE_WIDTH-1:0] mem_wline,
    input  logic [`LINE_WIDTH-1:0] mem_rline
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic       {GRANT_IC, GRANT_DC} grant_t;

    state_t           state;
    grant_t           grant;
    logic [CNT_W-1:0] cnt;
    logic             tie_dc;
    logic             pick_dc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Winner of the previous access. Only the round-robin tie-break reads it.
    grant_t last_grant;
    assign tie_dc = (last_grant == GRANT_IC);
`else
    assign tie_dc = 1'b1;
`endif

    // A single request always wins. A tie is settled by tie_dc.
    // NOTE: always_comb gives every output a default first, so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        pick_dc = 1'b0;
        if (dc_req && (!ic_req || tie_dc))
            pick_dc = 1'b1;
    end

    // The memory port registers double as the latched request. After the
    // grant, later changes on the request inputs cannot reach memory.
    // NOTE: all state here uses non-blocking assignments, so every register samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide line registers are reset too, because every output must read zero after reset, data included.
            state      <= IDLE;
            cnt        <= '0;
            grant      <= GRANT_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= GRANT_IC;
`endif
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wline  <= '0;
            ic_ready   <= 1'b0;
            dc_ready   <= 1'b0;
            ic_line    <= '0;
            dc_rline   <= '0;
        end else begin
            ic_ready <= 1'b0;
            dc_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        state  <= BUSY;
                        mem_en <= 1'b1;
                        cnt    <= CNT_W'(MEM_LATENCY - 1);
                        if (pick_dc) begin
                            grant     <= GRANT_DC;
                            mem_we    <= dc_we;
                            mem_addr  <= dc_addr;
                            mem_wline <= dc_wline;
                        end else begin
                            grant    <= GRANT_IC;
                            mem_we   <= 1'b0;
                            mem_addr <= ic_addr;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        // Last memory cycle: take the read data and raise
                        // ready so the pulse lands in DONE.
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (grant == GRANT_IC) begin
                            ic_ready <= 1'b1;
                            ic_line  <= mem_rline;
                        end else begin
                            dc_ready <= 1'b1;
                            if (!mem_we)
                                dc_rline <= mem_rline;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant <= grant;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_arbiter.sv
`timescale 1ns/1ps
`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif

module tb_line_mem_arbiter;

    localparam int LAT = 5;
    localparam int AW  = 32;
    localparam int LW  = `LINE_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic [LW-1:0] dc_wline = '0;
    logic          ic_ready, dc_ready, mem_en, mem_we;
    logic [LW-1:0] ic_line, dc_rline, mem_wline, mem_rline;
    logic [AW-1:0] mem_addr;

    // Second instance with the shortest legal latency.
    logic          f_ic_req = 1'b0, f_dc_req = 1'b0, f_dc_we = 1'b0;
    logic [AW-1:0] f_ic_addr = '0, f_dc_addr = '0;
    logic [LW-1:0] f_dc_wline = '0;
    logic          f_ic_ready, f_dc_ready, f_mem_en, f_mem_we;
    logic [LW-1:0] f_ic_line, f_dc_rline, f_mem_wline, f_mem_rline;
    logic [AW-1:0] f_mem_addr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data depends on address, and reads zero outside an access.
    function automatic logic [LW-1:0] pattern(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++)
            l[i*32 +: 32] = 32'(a) ^ 32'hA5A5_A5A5 ^ 32'(i);
        return l;
    endfunction

    assign mem_rline   = mem_en   ? pattern(mem_addr)   : '0;
    assign f_mem_rline = f_mem_en ? pattern(f_mem_addr) : '0;

    line_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_line(ic_line),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wline(dc_wline),
        .dc_ready(dc_ready), .dc_rline(dc_rline),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wline(mem_wline), .mem_rline(mem_rline)
    );

    line_mem_arbiter #(.MEM_LATENCY(1), .ADDR_WIDTH(AW)) dut_fast (
        .clk(clk), .reset(reset),
        .ic_req(f_ic_req), .ic_addr(f_ic_addr), .ic_ready(f_ic_ready), .ic_line(f_ic_line),
        .dc_req(f_dc_req), .dc_we(f_dc_we), .dc_addr(f_dc_addr), .dc_wline(f_dc_wline),
        .dc_ready(f_dc_ready), .dc_rline(f_dc_rline),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
        .mem_wline(f_mem_wline), .mem_rline(f_mem_rline)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard entries.
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wline;
        int            start;
        int            len;
    } mem_exp_t;

    typedef struct {
        logic [LW-1:0] line;
        int            cyc;
    } rdy_exp_t;

    mem_exp_t mem_q[$];
    rdy_exp_t ic_q[$];
    rdy_exp_t dc_q[$];

    // Reference model state.
    bit            lg_dc = 1'b0;    // last grant went to the dcache
    logic [LW-1:0] dc_rline_m = '0;

    // Queue the expected memory activity and completion for one access whose
    // request is sampled at the edge that makes cyc == start.
    task automatic push_access(input bit is_dc, input bit we, input logic [AW-1:0] a,
                               input logic [LW-1:0] wl, input int start);
        mem_exp_t m;
        rdy_exp_t r;
        m.addr = a; m.we = we; m.wline = wl; m.start = start; m.len = LAT;
        mem_q.push_back(m);
        r.cyc = start + LAT;
        if (is_dc) begin
            if (!we) dc_rline_m = pattern(a);
            r.line = dc_rline_m;
            dc_q.push_back(r);
        end else begin
            r.line = pattern(a);
            ic_q.push_back(r);
        end
        lg_dc = is_dc;
    endtask

    // Wait for n ready pulses, dropping each request right after its pulse.
    task automatic wait_readies(input int n);
        int seen = 0;
        for (int k = 0; k < 200 && seen < n; k++) begin
            @(negedge clk);
            if (ic_ready) begin ic_req = 1'b0; seen++; end
            if (dc_ready) begin dc_req = 1'b0; seen++; end
        end
        check("ready_count", seen, n);
    endtask

    task automatic single(input bit is_dc, input bit we, input logic [AW-1:0] a,
                          input logic [LW-1:0] wl);
        @(posedge clk); #1;
        if (is_dc) begin
            dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wline = wl;
        end else begin
            ic_req = 1'b1; ic_addr = a;
        end
        push_access(is_dc, we, a, wl, cyc + 1);
        wait_readies(1);
    endtask

    // Both requests raised together and held until each one completes.
    task automatic tie(input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input bit we, input logic [LW-1:0] wl);
        bit win_dc;
        int e;
        @(posedge clk); #1;
        ic_req = 1'b1; ic_addr = ia;
        dc_req = 1'b1; dc_we = we; dc_addr = da; dc_wline = wl;
        e = cyc + 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_dc = !lg_dc;
`else
        win_dc = 1'b1;
`endif
        if (win_dc) begin
            push_access(1'b1, we, da, wl, e);
            push_access(1'b0, 1'b0, ia, '0, e + LAT + 2);
        end else begin
            push_access(1'b0, 1'b0, ia, '0, e);
            push_access(1'b1, we, da, wl, e + LAT + 2);
        end
        wait_readies(2);
    endtask

    // Completion monitor.
    rdy_exp_t ic_r, dc_r;
    initial forever begin
        @(negedge clk);
        if (ic_ready) begin
            if (ic_q.size() == 0) check("ic_ready_unexpected", 1, 0);
            else begin
                ic_r = ic_q.pop_front();
                check("ic_line", ic_line, ic_r.line);
                check("ic_ready_cycle", cyc, ic_r.cyc);
            end
        end
        if (dc_ready) begin
            if (dc_q.size() == 0) check("dc_ready_unexpected", 1, 0);
            else begin
                dc_r = dc_q.pop_front();
                check("dc_rline", dc_rline, dc_r.line);
                check("dc_ready_cycle", cyc, dc_r.cyc);
            end
        end
    end

    // Memory port monitor: start cycle, length and stable address/controls.
    mem_exp_t cur_m;
    bit       have_m = 1'b0;
    bit       prev_en = 1'b0;
    int       run_len = 0;
    initial forever begin
        @(negedge clk);
        if (mem_en && !prev_en) begin
            run_len = 0;
            if (mem_q.size() == 0) begin
                check("mem_unexpected", 1, 0);
                have_m = 1'b0;
            end else begin
                cur_m  = mem_q.pop_front();
                have_m = 1'b1;
                check("mem_start", cyc, cur_m.start);
            end
        end
        if (mem_en) begin
            run_len++;
            if (have_m) begin
                check("mem_addr", mem_addr, cur_m.addr);
                check("mem_we", mem_we, cur_m.we);
                if (cur_m.we) check("mem_wline", mem_wline, cur_m.wline);
            end
        end
        if (!mem_en && prev_en && have_m)
            check("mem_len", run_len, cur_m.len);
        prev_en = mem_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wline", mem_wline, 0);
        check("rst_ic_ready", ic_ready, 0);
        check("rst_dc_ready", dc_ready, 0);
        check("rst_ic_line", ic_line, 0);
        check("rst_dc_rline", dc_rline, 0);
        check("rst_f_mem_en", f_mem_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        single(1'b0, 1'b0, 32'h40, '0);               // icache read
        tie(32'h140, 32'h180, 1'b0, '0);               // tie, dcache read
        tie(32'h240, 32'h280, 1'b1, LW'(128'hBEEF));   // tie, dcache write
        single(1'b1, 1'b1, 32'h80, LW'(128'h1234));    // dcache write
        single(1'b1, 1'b0, 32'hC0, '0);                // dcache read
        single(1'b1, 1'b1, 32'h100, LW'(128'h5678));   // write keeps dc_rline

        // Request changed and dropped mid-access: original access completes.
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h300;
        push_access(1'b1, 1'b0, 32'h300, '0, cyc + 1);
        repeat (2) @(posedge clk); #1;
        dc_addr = 32'h3F0; dc_we = 1'b1; dc_wline = LW'(128'hDEAD); dc_req = 1'b0;
        wait_readies(1);

        // Reset in the third BUSY cycle drops the access with no ready pulse.
        @(posedge clk); #1;
        ic_req = 1'b1; ic_addr = 32'h200;
        e = cyc + 1;
        begin
            mem_exp_t m;
            m.addr = 32'h200; m.we = 1'b0; m.wline = '0; m.start = e; m.len = 3;
            mem_q.push_back(m);
        end
        repeat (3) @(posedge clk); #1;
        check("rst_mid_cycle", cyc, e + 2);
        reset = 1'b1; ic_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_mem_en", mem_en, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_ic_ready", ic_ready, 0);
        check("midrst_ic_line", ic_line, 0);
        check("midrst_dc_rline", dc_rline, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dc_rline_m = '0;
        lg_dc = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_ready", ic_ready | dc_ready, 0);

        single(1'b0, 1'b0, 32'h440, '0);              // fresh icache read
        tie(32'h540, 32'h580, 1'b0, '0);              // tie again after reset

        // MEM_LATENCY = 1: one BUSY cycle, ready two cycles after the request.
        @(posedge clk); #1;
        f_ic_req = 1'b1; f_ic_addr = 32'h500;
        @(negedge clk);
        check("f_pre_mem_en", f_mem_en, 0);
        @(negedge clk);
        check("f_mem_en", f_mem_en, 1);
        check("f_mem_addr", f_mem_addr, 32'h500);
        check("f_ready_early", f_ic_ready, 0);
        @(negedge clk);
        check("f_mem_en_off", f_mem_en, 0);
        check("f_ic_ready", f_ic_ready, 1);
        check("f_ic_line", f_ic_line, pattern(32'h500));
        check("f_dc_ready", f_dc_ready, 0);
        f_ic_req = 1'b0;
        @(negedge clk);
        check("f_ready_once", f_ic_ready, 0);

        repeat (4) @(negedge clk);
        check("mem_q_empty", mem_q.size(), 0);
        check("ic_q_empty", ic_q.size(), 0);
        check("dc_q_empty", dc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Arbitrates one line-wide main-memory port between the instruction-cache miss path and the data-cache miss/writeback path. It sequences each access over a fixed memory latency and returns the full `LINE_WIDTH` line to the winning requester. Word extraction from the line is done downstream using the byte offset. The block sits between both caches and the memory model and is the only driver of the memory port.

## Interface
Parameters:
- `MEM_LATENCY`, default 5: memory access cycles. Legal range is ≥1.
- `ADDR_WIDTH`, default 32: byte address width.

Line width is the global macro `` `LINE_WIDTH ``.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  icache line-read request. Level signal, held until `ic_ready`.
- `ic_addr`  in  `ADDR_WIDTH`  icache line address.
- `ic_ready`  out  1  one-cycle completion pulse to the icache.
- `ic_line`  out  `LINE_WIDTH`  line returned to the icache. Valid while `ic_ready`=1 and held until the next icache completion.
- `dc_req`  in  1  dcache request. Level signal, held until `dc_ready`.
- `dc_we`  in  1  1 = line write (writeback), 0 = line read.
- `dc_addr`  in  `ADDR_WIDTH`  dcache line address.
- `dc_wline`  in  `LINE_WIDTH`  writeback data.
- `dc_ready`  out  1  one-cycle completion pulse to the dcache.
- `dc_rline`  out  `LINE_WIDTH`  line returned to the dcache. Updated only on read completion.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  `ADDR_WIDTH`  memory address.
- `mem_wline`  out  `LINE_WIDTH`  memory write data.
- `mem_rline`  in  `LINE_WIDTH`  memory read data. Valid in the last BUSY cycle.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE:**
  - With no request, the FSM stays in IDLE.
  - With any request, the arbiter selects a winner (see Configuration).
  - It latches the winner's addr/we/wline into internal registers, sets `grant` (IC/DC), loads `cnt` = `MEM_LATENCY`−1, and moves to BUSY.
- **BUSY:**
  - `mem_en`=1. `mem_addr`, `mem_we` and `mem_wline` are driven from the latched registers and are stable for the whole state.
  - When `cnt`≠0, `cnt` decrements.
  - When `cnt`=0, the block moves to DONE. On that edge it captures `mem_rline` into `ic_line` or `dc_rline` for reads; writes capture nothing.
- **DONE:**
  - The granted requester's ready pulse is 1 for exactly one cycle.
  - `last_grant` is set to `grant`, and the FSM returns to IDLE.
- The icache never issues writes. `mem_we` can only be 1 for a DC grant with `dc_we`=1.
- Deasserting a request during BUSY does not abort the access. It still completes and pulses ready.
- Request inputs are sampled only in IDLE. Changes to addr/we/wline after the grant are ignored.
- The ungranted requester waits with its request held. It is not lost.
- Reset values:
  - state = IDLE, `cnt` = 0, `grant` = IC, `last_grant` = IC.
  - `mem_en`, `mem_we`, `ic_ready` and `dc_ready` are 0.
  - `mem_addr`, `mem_wline`, `ic_line` and `dc_rline` are 0.
- Reset mid-operation: the in-flight access is dropped, with no ready pulse. The memory port deasserts on the next cycle.

## Timing
- The request is sampled in IDLE at edge 0. `mem_en` is 1 for cycles 1..`MEM_LATENCY`, and ready is 1 in cycle `MEM_LATENCY`+1.
- Total latency from request to ready is `MEM_LATENCY`+1 cycles.
- The earliest next grant is at the edge ending cycle `MEM_LATENCY`+2 (IDLE). Back-to-back throughput is one access per `MEM_LATENCY`+2 cycles.
- A requester must drop its request in the cycle after its ready pulse. A request still high in that IDLE cycle is treated as a new request.
- With `MEM_LATENCY`=1, BUSY lasts exactly one cycle.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, the requester not equal to `last_grant` wins. After reset (`last_grant`=IC) the DC wins the first tie.
- Not defined: fixed priority, where DC always wins a tie. The icache can starve under continuous dcache traffic, which is acceptable because dcache writebacks must drain first.
- In both modes, a single pending request is granted immediately.

## Test plan
- Icache read only, `MEM_LATENCY`=5, `ic_addr`=0x40, memory returns 0xA5 pattern:
  - `mem_en` is high for 5 cycles with `mem_addr`=0x40.
  - `ic_ready` pulses one cycle, 6 cycles after the request, with `ic_line`=pattern.
  - `dc_ready` stays 0.
- Dcache write, `dc_addr`=0x80, `dc_wline`=0x1234:
  - `mem_we`=1 and `mem_wline`=0x1234 for 5 cycles, then `dc_ready` pulses.
  - `dc_rline` is unchanged.
- Simultaneous `ic_req`/`dc_req` held for two transactions:
  - Both modes: DC is granted first, then IC.
  - Third tie with the round-robin macro: DC wins, and grants alternate.
  - Without the macro: DC wins every tie.
- `dc_addr` is changed and `dc_req` dropped mid-BUSY:
  - `mem_addr` keeps the original address.
  - `dc_ready` still pulses at cycle `MEM_LATENCY`+1.
- `reset` asserted in the 3rd BUSY cycle:
  - Next cycle `mem_en`=0 and all outputs are 0, with no ready pulse.
  - A fresh `ic_req` afterwards completes normally.
- `MEM_LATENCY`=1: `mem_en` is high for exactly 1 cycle, and ready arrives 2 cycles after the request.
